serial_nibble_adder: RTL and testbench
======================================

Name: serial_nibble_adder

Overview:
- Multi-nibble adder built around the existing combinational adder_4bit, which it instantiates once.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/4 clock cycles, one nibble (4 bits) per cycle, least-significant nibble first.
- The carry between nibbles is held in a register.
- Upstream producers connect through a valid/ready input handshake; downstream consumers connect through a valid/ready output handshake.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4: derived value, not overridable. Number of add cycles per operation.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set on in_a/in_b/in_cin is valid
- in_ready  output  1  block can accept an operand set
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in to the least-significant nibble
- out_valid  output  1  result on out_sum/out_cout is valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  WIDTH  sum, (in_a + in_b + in_cin) mod 2^WIDTH
- out_cout  output  1  carry out of the most-significant nibble

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low. Assertion immediately forces state IDLE.
  - On reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, carry register=0, nibble counter=0, operand shift registers=0.
  - Reset asserted mid-operation abandons the operation with no output.
- State machine (IDLE, ADD, DONE):
  - IDLE:
    - in_ready=1, out_valid=0.
    - On a clk edge with in_valid=1: capture in_a and in_b into shift registers, load the carry register with in_cin, clear the counter, go to ADD.
    - Operands are sampled only on this accepting edge.
  - ADD:
    - in_ready=0.
    - Each cycle, the low nibbles of the A/B shift registers and the carry register drive adder_4bit.
    - On each edge: shift A/B right by 4; shift the adder sum nibble into the top of the result register (result shifts right by 4); carry register takes cout; counter increments.
    - After the NIBBLES-th ADD edge, go to DONE. Only then is the result register fully populated.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_sum equals the result register; out_cout equals the carry register.
    - Both are held stable while out_ready=0.
    - On an edge with out_valid=1 and out_ready=1: go to IDLE.
- Output timing:
  - out_valid is registered, never combinational from inputs.
  - out_sum and out_cout keep their last value after leaving DONE; they are meaningful only while out_valid=1.
- Latency and throughput:
  - Accept at edge E; out_valid rises after edge E+NIBBLES.
  - Minimum period between accepts is NIBBLES+2 cycles (out_ready held at 1).
- Handshake rules:
  - in_valid during ADD or DONE is ignored. Upstream holds it until in_ready=1.
  - No input/output overlap: a new accept cannot occur on the same edge as an output handshake.
- Boundary conditions:
  - WIDTH=4: a single ADD cycle.
  - Carry ripples across nibble boundaries through the carry register only; the full all-ones case is required to propagate.
  - in_cin=1 with all-ones operands must produce out_sum all-ones and out_cout=1.

Test Plan:
- Basic add: WIDTH=16, in_a=0x1234, in_b=0x4321, in_cin=0, out_ready=1.
  -> out_sum=0x5555, out_cout=0; out_valid high exactly 4 edges after the accept; in_ready low during ADD/DONE.
- Full carry ripple: 0xFFFF + 0x0001 + 0.
  -> out_sum=0x0000, out_cout=1.
  - Also 0xFFFF + 0xFFFF + 1 -> out_sum=0xFFFF, out_cout=1.
- Carry-in with inter-nibble carries: 0x8888 + 0x8888 + 1.
  -> out_sum=0x1111, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and present a second operand set with in_valid=1 during this time.
  -> out_sum/out_cout stable and in_ready=0 throughout; second set not accepted.
  - After out_ready=1: return to IDLE, then accept the second set.
- Reset mid-operation: deassert rst_n during the 2nd ADD cycle.
  -> out_valid=0 and in_ready=1 immediately (asynchronous).
  - After release, 0x0001 + 0x0002 + 0 -> out_sum=0x0003, out_cout=0, with no stale result emitted.
- Random regression: 500 random operand sets with random in_valid/out_ready gaps, WIDTH=16 and WIDTH=4.
  -> each {out_cout,out_sum} equals in_a + in_b + in_cin; results in order; no results dropped or duplicated.

Source files
------------

// File: rtl/serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
//
// Adds two WIDTH-bit operands plus a carry-in one nibble per clock, least
// significant nibble first, using a single combinational 4-bit adder. The
// carry between nibbles lives in a register, so a full-width add takes
// WIDTH/4 cycles. Operands arrive over a valid/ready handshake and the
// result leaves over a second valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on in_a/in_b/in_cin is valid
//   in_ready   block can accept an operand set (high only when idle)
//   in_a/in_b  WIDTH-bit operands
//   in_cin     carry into the least significant nibble
//   out_valid  out_sum/out_cout hold a finished result
//   out_ready  downstream accepts the result
//   out_sum    (in_a + in_b + in_cin) mod 2^WIDTH
//   out_cout   carry out of the most significant nibble
// ---------------------------------------------------------------------------

// Plain combinational 4-bit adder; the serial adder reuses one instance.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module serial_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] sum_shifted;

    // The low nibbles of the operand shift registers plus the carry register
    // form the adder inputs every ADD cycle.
    adder_4bit u_adder (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New sum nibble enters at the top of the result register, so after
    // NIBBLES shifts the first (least significant) nibble sits at bit 0.
    generate
        if (WIDTH == 4) begin : g_single_nibble
            assign sum_shifted = nib_sum;
        end else begin : g_multi_nibble
            assign sum_shifted = {nib_sum, sum_q[WIDTH-1:4]};
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = ADD;
            ADD:  if (cnt_q == LAST_CNT) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; everything holds unless the state says otherwise.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                end
            end
            ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = sum_shifted;
                carry_d = nib_cout;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // Outputs decode only registered state, never the inputs. The carry
    // register doubles as out_cout once the last nibble has been added.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_sum   = sum_q;
        out_cout  = carry_q;
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_nibble_adder
//
// Drives a WIDTH=16 instance through directed cases (basic add, carry
// ripple, backpressure, mid-operation reset) and a random regression, while
// a WIDTH=4 instance runs its own random regression on a separate reset.
// Expected results are pushed to a queue at each accepted input handshake and
// compared while the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_serial_nibble_adder;
    localparam int W  = 16;
    localparam int N  = W / 4;
    localparam int W4 = 4;
    localparam int N4 = W4 / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, in_cin;
    logic          out_valid, out_cout;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a, in_b, out_sum;

    // WIDTH=4 instance
    logic          rst4_n = 1'b0;
    logic          in4_valid, in4_ready, in4_cin;
    logic          out4_valid, out4_cout;
    logic          out4_ready = 1'b1;
    logic [W4-1:0] in4_a, in4_b, out4_sum;

    serial_nibble_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    serial_nibble_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .in_valid(in4_valid), .in_ready(in4_ready),
        .in_a(in4_a), .in_b(in4_b), .in_cin(in4_cin),
        .out_valid(out4_valid), .out_ready(out4_ready),
        .out_sum(out4_sum), .out_cout(out4_cout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready for the 16-bit DUT: 0 = hold low, 1 = hold high, 2 = random
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        out_ready  = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        out4_ready = ($urandom_range(0, 2) != 0);
    end

    typedef struct {
        logic [W:0] exp;
        int         acc;
    } txn16_t;
    typedef struct {
        logic [W4:0] exp;
        int          acc;
    } txn4_t;

    txn16_t q16[$];
    txn4_t  q4[$];
    logic   ov_prev  = 1'b0;
    logic   ov4_prev = 1'b0;

    // Scoreboard for the 16-bit DUT. Sampled on the falling edge, so the
    // values seen here are what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready16", 32'(in_ready), 32'(q16.size() == 0));
            if (in_valid && in_ready)
                q16.push_back('{{1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin}, cyc});
            if (out_valid) begin
                if (q16.size() == 0) check("spurious16", 32'(out_valid), 32'd0);
                else begin
                    if (!ov_prev) check("latency16", 32'(cyc - q16[0].acc), 32'(N + 1));
                    check("sum16", 32'({out_cout, out_sum}), 32'(q16[0].exp));
                    if (out_ready) void'(q16.pop_front());
                end
            end
        end
        ov_prev <= out_valid;
    end

    always @(negedge clk) begin
        if (rst4_n) begin
            check("in_ready4", 32'(in4_ready), 32'(q4.size() == 0));
            if (in4_valid && in4_ready)
                q4.push_back('{{1'b0, in4_a} + {1'b0, in4_b} + {{W4{1'b0}}, in4_cin}, cyc});
            if (out4_valid) begin
                if (q4.size() == 0) check("spurious4", 32'(out4_valid), 32'd0);
                else begin
                    if (!ov4_prev) check("latency4", 32'(cyc - q4[0].acc), 32'(N4 + 1));
                    check("sum4", 32'({out4_cout, out4_sum}), 32'(q4[0].exp));
                    if (out4_ready) void'(q4.pop_front());
                end
            end
        end
        ov4_prev <= out4_valid;
    end

    // Hold an operand set valid until the DUT accepts it.
    task automatic send16(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic acc;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                in_a = W'($urandom);
                return;
            end
        end
        check("accept_timeout16", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain16();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (q16.size() == 0) return;
        end
        check("drain_timeout16", 32'(q16.size()), 32'd0);
        q16.delete();
    endtask

    task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic cin);
        logic acc;
        in4_a = a; in4_b = b; in4_cin = cin; in4_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in4_ready;
            @(posedge clk); #1;
            if (acc) begin
                in4_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout4", 32'd1, 32'd0);
        in4_valid = 1'b0;
    endtask

    logic done4 = 1'b0;

    initial begin : rand4
        in4_valid = 1'b0; in4_a = '0; in4_b = '0; in4_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst4_in_ready", 32'(in4_ready), 32'd1);
        check("rst4_out_valid", 32'(out4_valid), 32'd0);
        rst4_n = 1'b1;
        send4(4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send4(W4'($urandom), W4'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 100 && q4.size() != 0; k++) begin @(posedge clk); #1; end
        check("drain4", 32'(q4.size()), 32'd0);
        done4 = 1'b1;
    end

    initial begin : main
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        rst_n = 1'b1;

        // Directed sums
        send16(16'h1234, 16'h4321, 1'b0); drain16();
        send16(16'hFFFF, 16'h0001, 1'b0); drain16();
        send16(16'hFFFF, 16'hFFFF, 1'b1); drain16();
        send16(16'h8888, 16'h8888, 1'b1); drain16();

        // Backpressure with a second operand set waiting upstream
        ready_mode = 0;
        @(posedge clk); #1;
        send16(16'h0F0F, 16'h7070, 1'b1);
        for (int k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_sum", 32'(out_sum), 32'h7F80);
        end
        ready_mode = 1;
        send16(16'hAAAA, 16'h5555, 1'b1); drain16();

        // Reset during the second ADD cycle abandons the operation
        send16(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q16.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_sum", 32'(out_sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send16(16'h0001, 16'h0002, 1'b0); drain16();

        // Random regression
        ready_mode = 2;
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send16(W'($urandom), W'($urandom), 1'($urandom));
        end
        drain16();

        for (int k = 0; k < 5000 && !done4; k++) @(posedge clk);
        check("done4", 32'(done4), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
